dcache_assoc: RTL and testbench

N-way set-associative, write-back, write-allocate L1 data cache. It replaces the direct-mapped dcache between the pipeline memory stage and the L2. The pipe and L2 handshakes are unchanged, so it drops in at the same hierarchy point. Controller and datapath live in one module with way-parametrised tag/data arrays and a replacement policy.

---
 rtl/dcache_assoc_if.sv | 54 +++++
 rtl/dcache_assoc.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_dcache_assoc.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_assoc_if.sv
// ---------------------------------------------------------------------------
// dcache_assoc_if / dcache_assoc_pkg
//
// Purpose:
//   Shared operation encodings, and the bundled handshake between the
//   pipeline memory stage, the L1 data cache and the L2.
//
// Modports:
//   master : pipeline/L2 side. Drives pipe_req_* and the L2 responses.
//   slave  : cache side. Answers the pipe and issues L2 requests.
//
// Signals:
//   pipe_req_address/size/type/valid, pipe_word_to_store   pipe -> cache
//   pipe_fetched_word, pipe_req_fulfilled                  cache -> pipe
//   l2_req_address/type/valid, l2_word_to_store            cache -> L2
//   l2_fetched_word, l2_req_fulfilled                      L2 -> cache
// ---------------------------------------------------------------------------
package dcache_assoc_pkg;
    typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_operation_size_e;
    typedef enum logic [1:0] {LOAD = 2'd0, STORE = 2'd1, CLFLUSH = 2'd2} memory_operation_e;
endpackage

interface dcache_assoc_if #(parameter int XLEN = 32);
    import dcache_assoc_pkg::*;

    logic [XLEN-1:0]        pipe_req_address;
    memory_operation_size_e pipe_req_size;
    memory_operation_e      pipe_req_type;
    logic                   pipe_req_valid;
    logic [XLEN-1:0]        pipe_word_to_store;
    logic [XLEN-1:0]        pipe_fetched_word;
    logic                   pipe_req_fulfilled;

    logic [XLEN-1:0]        l2_req_address;
    memory_operation_e      l2_req_type;
    logic                   l2_req_valid;
    logic [XLEN-1:0]        l2_word_to_store;
    logic [XLEN-1:0]        l2_fetched_word;
    logic                   l2_req_fulfilled;

    modport master (
        output pipe_req_address, pipe_req_size, pipe_req_type, pipe_req_valid, pipe_word_to_store,
        input  pipe_fetched_word, pipe_req_fulfilled,
        input  l2_req_address, l2_req_type, l2_req_valid, l2_word_to_store,
        output l2_fetched_word, l2_req_fulfilled
    );

    modport slave (
        input  pipe_req_address, pipe_req_size, pipe_req_type, pipe_req_valid, pipe_word_to_store,
        output pipe_fetched_word, pipe_req_fulfilled,
        output l2_req_address, l2_req_type, l2_req_valid, l2_word_to_store,
        input  l2_fetched_word, l2_req_fulfilled
    );
endinterface

// File: rtl/dcache_assoc.sv
// ---------------------------------------------------------------------------
// dcache_assoc
//
// Purpose:
//   N-way set-associative, write-back, write-allocate L1 data cache sitting
//   between the pipeline memory stage and the L2. Hits complete in the
//   request cycle; misses write back a dirty victim, then fill the line
//   word by word, after which the held request hits.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   bus          dcache_assoc_if.slave (pipe request/response, L2 request/response)
//   perf_hits, perf_misses, perf_writebacks   (only with DCACHE_PERF_COUNTERS_EN)
//
// Build option:
//   DCACHE_PERF_COUNTERS_EN  adds saturating 32-bit hit/miss/writeback counters.
// ---------------------------------------------------------------------------

// Tag match for one way of the indexed set.
module dcache_assoc_way_cmp #(parameter int TAG_W = 23) (
    input  logic             valid,
    input  logic [TAG_W-1:0] way_tag,
    input  logic [TAG_W-1:0] req_tag,
    output logic             hit
);
    assign hit = valid && (way_tag == req_tag);
endmodule

module dcache_assoc
    import dcache_assoc_pkg::*;
#(
    parameter int LINE_SIZE  = 32,
    parameter int CACHE_SIZE = 1024,
    parameter int NUM_WAYS   = 2,
    parameter int XLEN       = 32
) (
    input logic          clk,
    input logic          reset,
    dcache_assoc_if.slave bus
`ifdef DCACHE_PERF_COUNTERS_EN
    ,
    output logic [31:0]  perf_hits,
    output logic [31:0]  perf_misses,
    output logic [31:0]  perf_writebacks
`endif
);
    localparam int NUM_SETS = CACHE_SIZE / (LINE_SIZE * NUM_WAYS);
    localparam int WORDS    = LINE_SIZE / (XLEN / 8);
    localparam int OFF_W    = $clog2(LINE_SIZE);
    localparam int SET_W    = $clog2(NUM_SETS);
    localparam int TAG_W    = XLEN - OFF_W - SET_W;
    localparam int WORD_W   = $clog2(WORDS);
    localparam int BOFF_W   = $clog2(XLEN / 8);
    localparam int WAY_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL, FLUSH_WB} state_e;

    // Arrays
    logic [XLEN-1:0]     data_mem [NUM_WAYS][NUM_SETS][WORDS];
    logic [TAG_W-1:0]    tag_mem  [NUM_WAYS][NUM_SETS];
    logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];
    logic [WAY_W-1:0]    rr_q     [NUM_SETS];

    // Controller state
    state_e            state;
    logic [WAY_W-1:0]  vic_q;
    logic [WORD_W-1:0] cnt_q;
    logic [SET_W-1:0]  set_q;
    logic [TAG_W-1:0]  tag_q;
    logic [XLEN-1:0]   l2_addr_q;
    logic [XLEN-1:0]   l2_wdata_q;
    logic              l2_valid_q;
    memory_operation_e l2_type_q;

    // Request decode
    logic [SET_W-1:0]  req_set;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_word;
    logic [BOFF_W-1:0] req_byte;

    assign req_set  = bus.pipe_req_address[OFF_W +: SET_W];
    assign req_tag  = bus.pipe_req_address[XLEN-1 -: TAG_W];
    assign req_word = bus.pipe_req_address[BOFF_W +: WORD_W];
    assign req_byte = bus.pipe_req_address[BOFF_W-1:0];

    logic [NUM_WAYS-1:0]            hit_vec;
    logic [NUM_WAYS-1:0][TAG_W-1:0] set_tags;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        assign set_tags[w] = tag_mem[w][req_set];
        dcache_assoc_way_cmp #(.TAG_W(TAG_W)) u_cmp (
            .valid   (valid_q[req_set][w]),
            .way_tag (set_tags[w]),
            .req_tag (req_tag),
            .hit     (hit_vec[w])
        );
    end

    logic [WAY_W-1:0] hit_way, vic_way;
    logic             hit, hit_dirty, vic_dirty;

    // Descending scans so the lowest matching/invalid index wins.
    always_comb begin
        hit_way = '0;
        vic_way = rr_q[req_set];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (hit_vec[w])           hit_way = WAY_W'(w);
            if (!valid_q[req_set][w]) vic_way = WAY_W'(w);
        end
    end

    assign hit       = |hit_vec;
    assign hit_dirty = dirty_q[req_set][hit_way];
    assign vic_dirty = valid_q[req_set][vic_way] && dirty_q[req_set][vic_way];

    // Lane alignment: sub-size low address bits are dropped before shifting.
    logic [BOFF_W-1:0] lane;
    logic [XLEN-1:0]   size_mask, hit_word, st_mask, merged, load_data;
    logic [BOFF_W+2:0] shamt;

    always_comb begin
        case (bus.pipe_req_size)
            BYTE:    begin lane = req_byte;                    size_mask = XLEN'(8'hFF);        end
            HALF:    begin lane = req_byte & ~BOFF_W'(1);      size_mask = XLEN'(16'hFFFF);     end
            default: begin lane = req_byte & ~BOFF_W'(3);      size_mask = XLEN'(32'hFFFF_FFFF); end
        endcase
        shamt     = {lane, 3'b000};
        hit_word  = data_mem[hit_way][req_set][req_word];
        st_mask   = size_mask << shamt;
        merged    = (hit_word & ~st_mask) | ((bus.pipe_word_to_store << shamt) & st_mask);
        load_data = (hit_word >> shamt) & size_mask;
    end

    logic active, is_cl, fulfil, fill_last;
    logic [WORD_W-1:0] cur_word, nxt_word;

    assign active = !reset && state == IDLE && bus.pipe_req_valid;
    assign is_cl  = bus.pipe_req_type == CLFLUSH;
    // A dirty CLFLUSH hit completes later, when the held request misses after FLUSH_WB.
    assign fulfil = active && (is_cl ? !(hit && hit_dirty) : hit);

    assign bus.pipe_req_fulfilled = fulfil;
    assign bus.pipe_fetched_word  = (fulfil && bus.pipe_req_type == LOAD) ? load_data : '0;
    assign bus.l2_req_address     = l2_addr_q;
    assign bus.l2_req_type        = l2_type_q;
    assign bus.l2_req_valid       = l2_valid_q;
    assign bus.l2_word_to_store   = l2_wdata_q;

    // Counter runs down while words go up, so the word index is its complement.
    assign cur_word  = ~cnt_q;
    assign nxt_word  = cur_word + 1'b1;
    assign fill_last = state == FILL && bus.l2_req_fulfilled && cnt_q == '0;

    // Data and tag arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (active && hit && bus.pipe_req_type == STORE)
                data_mem[hit_way][req_set][req_word] <= merged;
            if (state == FILL && bus.l2_req_fulfilled)
                data_mem[vic_q][set_q][cur_word] <= bus.l2_fetched_word;
            if (fill_last)
                tag_mem[vic_q][set_q] <= tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            vic_q      <= '0;
            cnt_q      <= '0;
            set_q      <= '0;
            tag_q      <= '0;
            l2_addr_q  <= '0;
            l2_wdata_q <= '0;
            l2_valid_q <= 1'b0;
            l2_type_q  <= LOAD;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            case (state)
                IDLE: if (bus.pipe_req_valid) begin
                    if (is_cl) begin
                        if (hit && hit_dirty) begin
                            state      <= FLUSH_WB;
                            vic_q      <= hit_way;
                            set_q      <= req_set;
                            cnt_q      <= '1;
                            l2_valid_q <= 1'b1;
                            l2_type_q  <= STORE;
                            l2_addr_q  <= {req_tag, req_set, {OFF_W{1'b0}}};
                            l2_wdata_q <= data_mem[hit_way][req_set][0];
                        end else if (hit) begin
                            valid_q[req_set][hit_way] <= 1'b0;
                        end
                    end else if (hit) begin
                        if (bus.pipe_req_type == STORE)
                            dirty_q[req_set][hit_way] <= 1'b1;
                    end else begin
                        vic_q      <= vic_way;
                        set_q      <= req_set;
                        tag_q      <= req_tag;
                        cnt_q      <= '1;
                        l2_valid_q <= 1'b1;
                        if (vic_dirty) begin
                            state      <= WRITEBACK;
                            l2_type_q  <= STORE;
                            l2_addr_q  <= {tag_mem[vic_way][req_set], req_set, {OFF_W{1'b0}}};
                            l2_wdata_q <= data_mem[vic_way][req_set][0];
                        end else begin
                            // Victim is overwritten from here on, so it must not hit.
                            state                     <= FILL;
                            valid_q[req_set][vic_way] <= 1'b0;
                            l2_type_q                 <= LOAD;
                            l2_addr_q                 <= {req_tag, req_set, {OFF_W{1'b0}}};
                            l2_wdata_q                <= '0;
                        end
                    end
                end
                WRITEBACK, FLUSH_WB: if (bus.l2_req_fulfilled) begin
                    if (cnt_q == '0) begin
                        valid_q[set_q][vic_q] <= 1'b0;
                        dirty_q[set_q][vic_q] <= 1'b0;
                        l2_wdata_q            <= '0;
                        l2_type_q             <= LOAD;
                        if (state == FLUSH_WB) begin
                            state      <= IDLE;
                            l2_valid_q <= 1'b0;
                            l2_addr_q  <= '0;
                        end else begin
                            state     <= FILL;
                            cnt_q     <= '1;
                            l2_addr_q <= {tag_q, set_q, {OFF_W{1'b0}}};
                        end
                    end else begin
                        cnt_q      <= cnt_q - 1'b1;
                        l2_addr_q  <= {l2_addr_q[XLEN-1:OFF_W], nxt_word, {BOFF_W{1'b0}}};
                        l2_wdata_q <= data_mem[vic_q][set_q][nxt_word];
                    end
                end
                FILL: if (bus.l2_req_fulfilled) begin
                    if (cnt_q == '0) begin
                        state                 <= IDLE;
                        valid_q[set_q][vic_q] <= 1'b1;
                        dirty_q[set_q][vic_q] <= 1'b0;
                        rr_q[set_q]           <= (rr_q[set_q] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[set_q] + 1'b1;
                        l2_valid_q            <= 1'b0;
                        l2_addr_q             <= '0;
                    end else begin
                        cnt_q     <= cnt_q - 1'b1;
                        l2_addr_q <= {l2_addr_q[XLEN-1:OFF_W], nxt_word, {BOFF_W{1'b0}}};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DCACHE_PERF_COUNTERS_EN
    // The hit that completes a just-filled request is not counted as a hit.
    logic filled_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            filled_q        <= 1'b0;
            perf_hits       <= '0;
            perf_misses     <= '0;
            perf_writebacks <= '0;
        end else begin
            if (fill_last)           filled_q <= 1'b1;
            else if (state == IDLE)  filled_q <= 1'b0;
            if (active && !is_cl && hit && !filled_q && perf_hits != '1)
                perf_hits <= perf_hits + 1'b1;
            if (active && !is_cl && !hit && perf_misses != '1)
                perf_misses <= perf_misses + 1'b1;
            if (active && ((!is_cl && !hit && vic_dirty) || (is_cl && hit && hit_dirty)) &&
                perf_writebacks != '1)
                perf_writebacks <= perf_writebacks + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
module tb_dcache_assoc;
    import dcache_assoc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_assoc_if #(.XLEN(32)) bus ();

`ifdef DCACHE_PERF_COUNTERS_EN
    logic [31:0] perf_hits, perf_misses, perf_writebacks;
`endif

    dcache_assoc #(.LINE_SIZE(32), .CACHE_SIZE(1024), .NUM_WAYS(2), .XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef DCACHE_PERF_COUNTERS_EN
        ,
        .perf_hits       (perf_hits),
        .perf_misses     (perf_misses),
        .perf_writebacks (perf_writebacks)
`endif
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
        int          c;
    } beat_t;

    beat_t obs_q[$];
    beat_t exp_q[$];
    logic  l2_en = 1'b1;
    logic  gap = 1'b0;

    // L2 model: answers every other cycle with 0x1000+address; logs each beat.
    always @(posedge clk) begin
        #1;
        if (l2_en && bus.l2_req_valid && !gap) begin
            bus.l2_req_fulfilled = 1'b1;
            bus.l2_fetched_word  = 32'h1000 + bus.l2_req_address;
            obs_q.push_back('{bus.l2_req_type, bus.l2_req_address,
                              (bus.l2_req_type == STORE) ? bus.l2_word_to_store : 32'h1000 + bus.l2_req_address,
                              cyc});
            gap = 1'b1;
        end else begin
            bus.l2_req_fulfilled = 1'b0;
            gap = 1'b0;
        end
    end

    function automatic void exp_line(input logic [1:0] op, input logic [31:0] base);
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{op, base + 32'(4 * i), 32'h1000 + base + 32'(4 * i), 0});
    endfunction

    // Drive one request and hold it until the cache fulfils it (bounded).
    task automatic issue(input memory_operation_e op, input memory_operation_size_e sz,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output int lat, output int fcyc);
        bit done;
        @(posedge clk); #3;
        bus.pipe_req_type      = op;
        bus.pipe_req_size      = sz;
        bus.pipe_req_address   = addr;
        bus.pipe_word_to_store = wd;
        bus.pipe_req_valid     = 1'b1;
        done = 0; lat = 0; rd = '0; fcyc = -1;
        while (!done && lat < 300) begin
            #1;
            if (bus.pipe_req_fulfilled) begin
                rd = bus.pipe_fetched_word; fcyc = cyc; done = 1;
            end else begin
                @(posedge clk); #3; lat++;
            end
        end
        @(posedge clk); #3;
        bus.pipe_req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.pipe_req_type = LOAD; bus.pipe_req_size = WORD;
        bus.pipe_req_address = 32'h100; bus.pipe_req_valid = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        checks++; if (bus.l2_req_valid !== 1'b0) begin failures++; $display("FAIL reset_l2_valid got=%b want=0", bus.l2_req_valid); end
        checks++; if (bus.pipe_req_fulfilled !== 1'b0) begin failures++; $display("FAIL reset_fulfilled got=%b want=0", bus.pipe_req_fulfilled); end
        checks++; if (bus.pipe_fetched_word !== 32'h0) begin failures++; $display("FAIL reset_fetched got=%h want=0", bus.pipe_fetched_word); end
        checks++; if (bus.l2_req_address !== 32'h0) begin failures++; $display("FAIL reset_l2_addr got=%h want=0", bus.l2_req_address); end
        checks++; if (bus.l2_word_to_store !== 32'h0) begin failures++; $display("FAIL reset_l2_wdata got=%h want=0", bus.l2_word_to_store); end
        reset = 1'b0; bus.pipe_req_valid = 1'b0;
    endtask

    task automatic test_cold_load;
        logic [31:0] rd; int lat, fc; beat_t e, o;
        obs_q.delete(); exp_q.delete();
        exp_line(LOAD, 32'h100);
        issue(LOAD, WORD, 32'h100, 0, rd, lat, fc);
        checks++; if (rd !== 32'h1100) begin failures++; $display("FAIL cold_load_data got=%h want=00001100", rd); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL cold_load_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.op !== e.op || o.addr !== e.addr || o.data !== e.data) begin
                failures++; $display("FAIL cold_load_beat got=%0d/%h/%h want=%0d/%h/%h", o.op, o.addr, o.data, e.op, e.addr, e.data);
            end
        end
    endtask

    task automatic test_store_hit;
        logic [31:0] rd; int lat, fc;
        obs_q.delete();
        issue(STORE, BYTE, 32'h101, 32'hAB, rd, lat, fc);
        checks++; if (lat != 0) begin failures++; $display("FAIL store_hit_latency got=%0d want=0", lat); end
        issue(LOAD, WORD, 32'h100, 0, rd, lat, fc);
        checks++; if (rd !== 32'h0000AB00 || lat != 0) begin failures++; $display("FAIL load_merged got=%h/%0d want=0000ab00/0", rd, lat); end
        issue(LOAD, BYTE, 32'h101, 0, rd, lat, fc);
        checks++; if (rd !== 32'h000000AB) begin failures++; $display("FAIL load_byte got=%h want=000000ab", rd); end
        issue(LOAD, HALF, 32'h105, 0, rd, lat, fc);
        checks++; if (rd !== 32'h00001104) begin failures++; $display("FAIL load_half_bit0 got=%h want=00001104", rd); end
        issue(LOAD, WORD, 32'h10B, 0, rd, lat, fc);
        checks++; if (rd !== 32'h00001108) begin failures++; $display("FAIL load_word_low2 got=%h want=00001108", rd); end
        issue(LOAD, BYTE, 32'h109, 0, rd, lat, fc);
        checks++; if (rd !== 32'h00000011) begin failures++; $display("FAIL load_byte_lane1 got=%h want=00000011", rd); end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL hit_l2_traffic got=%0d want=0", obs_q.size()); end
    endtask

    task automatic test_evict;
        logic [31:0] rd; int lat, fc; beat_t e, o;
        obs_q.delete(); exp_q.delete();
        exp_line(LOAD, 32'h300);
        issue(LOAD, WORD, 32'h300, 0, rd, lat, fc);
        checks++; if (rd !== 32'h1300) begin failures++; $display("FAIL evict_load300 got=%h want=00001300", rd); end
        exp_line(STORE, 32'h100);
        exp_q[8].data = 32'h0000AB00;
        exp_line(LOAD, 32'h500);
        issue(LOAD, WORD, 32'h500, 0, rd, lat, fc);
        checks++; if (rd !== 32'h1500) begin failures++; $display("FAIL evict_load500 got=%h want=00001500", rd); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL evict_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.op !== e.op || o.addr !== e.addr || o.data !== e.data) begin
                failures++; $display("FAIL evict_beat got=%0d/%h/%h want=%0d/%h/%h", o.op, o.addr, o.data, e.op, e.addr, e.data);
            end
        end
    endtask

    task automatic test_flush;
        logic [31:0] rd; int lat, fc, last_c; beat_t e, o;
        obs_q.delete(); exp_q.delete();
        issue(CLFLUSH, WORD, 32'h300, 0, rd, lat, fc);
        checks++; if (lat != 0 || obs_q.size() != 0) begin failures++; $display("FAIL flush_clean got=%0d/%0d want=0/0", lat, obs_q.size()); end
        exp_line(LOAD, 32'h300);
        issue(LOAD, WORD, 32'h300, 0, rd, lat, fc);
        checks++; if (rd !== 32'h1300 || obs_q.size() != 8) begin failures++; $display("FAIL flush_reload got=%h/%0d want=00001300/8", rd, obs_q.size()); end
        obs_q.delete(); exp_q.delete();
        issue(CLFLUSH, WORD, 32'hF00, 0, rd, lat, fc);
        checks++; if (lat != 0 || obs_q.size() != 0) begin failures++; $display("FAIL flush_miss got=%0d/%0d want=0/0", lat, obs_q.size()); end
        issue(STORE, WORD, 32'h504, 32'h12345678, rd, lat, fc);
        exp_line(STORE, 32'h500);
        exp_q[1].data = 32'h12345678;
        issue(CLFLUSH, WORD, 32'h500, 0, rd, lat, fc);
        last_c = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].c : -9;
        checks++; if (fc != last_c + 1) begin failures++; $display("FAIL flush_dirty_done got=%0d want=%0d", fc, last_c + 1); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL flush_dirty_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.op !== e.op || o.addr !== e.addr || o.data !== e.data) begin
                failures++; $display("FAIL flush_beat got=%0d/%h/%h want=%0d/%h/%h", o.op, o.addr, o.data, e.op, e.addr, e.data);
            end
        end
        obs_q.delete();
        issue(LOAD, WORD, 32'h504, 0, rd, lat, fc);
        checks++; if (rd !== 32'h1504 || obs_q.size() != 8) begin failures++; $display("FAIL flush_dirty_reload got=%h/%0d want=00001504/8", rd, obs_q.size()); end
    endtask

    task automatic test_store_miss;
        logic [31:0] rd; int lat, fc;
        obs_q.delete();
        issue(STORE, HALF, 32'hA02, 32'hBEEF, rd, lat, fc);
        checks++; if (obs_q.size() != 8 || obs_q[0].addr !== 32'hA00 || obs_q[0].op !== 2'(LOAD))
            begin failures++; $display("FAIL store_miss_fill got=%0d beats want=8 from 00000a00", obs_q.size()); end
        issue(LOAD, WORD, 32'hA00, 0, rd, lat, fc);
        checks++; if (rd !== 32'hBEEF1A00 || lat != 0) begin failures++; $display("FAIL store_miss_merge got=%h/%0d want=beef1a00/0", rd, lat); end
    endtask

    task automatic test_fill_timing;
        logic [31:0] rd; int lat, fc, last_c;
        obs_q.delete();
        issue(LOAD, WORD, 32'h940, 0, rd, lat, fc);
        last_c = (obs_q.size() > 0) ? obs_q[obs_q.size() - 1].c : -9;
        checks++; if (fc != last_c + 1) begin failures++; $display("FAIL fill_done_cycle got=%0d want=%0d", fc, last_c + 1); end
        checks++; if (rd !== 32'h1940) begin failures++; $display("FAIL fill_data got=%h want=00001940", rd); end
        #1;
        checks++; if (bus.pipe_req_fulfilled !== 1'b0 || bus.l2_req_valid !== 1'b0)
            begin failures++; $display("FAIL fill_single_pulse got=%b/%b want=0/0", bus.pipe_req_fulfilled, bus.l2_req_valid); end
    endtask

    task automatic test_reset_midfill;
        int n; bit done; logic [31:0] rd; beat_t e, o;
        obs_q.delete(); exp_q.delete();
        @(posedge clk); #3;
        bus.pipe_req_type = LOAD; bus.pipe_req_size = WORD;
        bus.pipe_req_address = 32'h700; bus.pipe_req_valid = 1'b1;
        n = 0;
        while (obs_q.size() < 3 && n < 200) begin @(posedge clk); #3; n++; end
        l2_en = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.l2_req_valid !== 1'b0 || bus.pipe_req_fulfilled !== 1'b0)
            begin failures++; $display("FAIL midfill_reset got=%b/%b want=0/0", bus.l2_req_valid, bus.pipe_req_fulfilled); end
        checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL midfill_beats got=%0d want=3", obs_q.size()); end
        reset = 1'b0; l2_en = 1'b1;
        obs_q.delete();
        exp_line(LOAD, 32'h700);
        done = 0; n = 0; rd = '0;
        while (!done && n < 300) begin
            @(posedge clk); #4; n++;
            if (bus.pipe_req_fulfilled) begin rd = bus.pipe_fetched_word; done = 1; end
        end
        @(posedge clk); #3;
        bus.pipe_req_valid = 1'b0;
        checks++; if (rd !== 32'h1700) begin failures++; $display("FAIL midfill_refill_data got=%h want=00001700", rd); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL midfill_refill_beats got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
            if (o.op !== e.op || o.addr !== e.addr || o.data !== e.data) begin
                failures++; $display("FAIL midfill_beat got=%0d/%h/%h want=%0d/%h/%h", o.op, o.addr, o.data, e.op, e.addr, e.data);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.pipe_req_valid = 1'b0;
        bus.pipe_req_address = '0;
        bus.pipe_req_size = WORD;
        bus.pipe_req_type = LOAD;
        bus.pipe_word_to_store = '0;
        bus.l2_req_fulfilled = 1'b0;
        bus.l2_fetched_word = '0;
        test_reset();
        test_cold_load();
        test_store_hit();
        test_evict();
        test_flush();
        test_store_miss();
        test_fill_timing();
        test_reset_midfill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
